// File: rtl/instream_gen.sv
// instream_gen: deterministic multi-channel frame source with optional idle gaps.
// Ports: clk/reset (sync, active-high), start_in/stop_in level controls,
//   ready in; valid, data_out (NCH x DW), eol_out, last_out, busy, done,
//   beat_cnt out.
module instream_gen #(
   parameter int          NCH          = 3,
   parameter int          DW           = 8,
   parameter int          WIDTH        = 260,
   parameter int          HEIGHT       = 258,
   parameter int          CH_STEP      = 1,
   parameter int          STALL_MODE   = 1,
   parameter logic [15:0] SEED         = 16'hACE1,
   parameter int          STALL_PERIOD = 4,
   parameter int          STALL_LEN    = 2
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start_in,
   input  logic                                   stop_in,
   input  logic                                   ready,
   output logic                                   valid,
   output logic [NCH*DW-1:0]                      data_out,
   output logic                                   eol_out,
   output logic                                   last_out,
   output logic                                   busy,
   output logic                                   done,
   output logic [$clog2(WIDTH*HEIGHT+1)-1:0]      beat_cnt
);

   localparam int TOTAL = WIDTH * HEIGHT;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
   localparam int LW    = $clog2(STALL_LEN + 1);
   localparam int GW    = (LW > 6) ? LW : 6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STALL,
      S_SEND,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [XW-1:0]   x_q, x_d;
   logic [PW-1:0]   per_q, per_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [15:0]     lfsr_q, lfsr_d;

   logic            is_eol;
   logic            is_last;
   logic            per_hit;
   logic            decide;
   logic [GW-1:0]   gap_g;
   logic [15:0]     lfsr_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         x_q     <= '0;
         per_q   <= '0;
         gap_q   <= '0;
         lfsr_q  <= SEED;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         x_q     <= x_d;
         per_q   <= per_d;
         gap_q   <= gap_d;
         lfsr_q  <= lfsr_d;
      end
   end

   always_comb begin
      is_eol   = (x_q == XW'(WIDTH - 1));
      is_last  = (idx_q == CW'(TOTAL - 1));
      // per_q counts accepted beats modulo STALL_PERIOD, so a hit means
      // the beat about to be accepted lands on a multiple of the period
      per_hit  = (per_q == PW'(STALL_PERIOD - 1));
      lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                  lfsr_q[15:1]};

      gap_g = '0;
      if (STALL_MODE == 1) begin
         if (lfsr_q[0]) gap_g = GW'(lfsr_q[5:1]) + GW'(1);
      end else if (STALL_MODE == 2) begin
         if (state_q == S_SEND && per_hit) gap_g = GW'(STALL_LEN);
      end

      state_d = state_q;
      idx_d   = idx_q;
      x_d     = x_q;
      per_d   = per_q;
      gap_d   = gap_q;
      lfsr_d  = lfsr_q;
      decide  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start_in) begin
               decide = 1'b1;
               per_d  = '0;
            end
         end
         S_STALL: begin
            gap_d = gap_q - GW'(1);
            if (gap_q == GW'(1)) state_d = S_SEND;
         end
         S_SEND: begin
            if (ready) begin
               idx_d = idx_q + CW'(1);
               x_d   = is_eol ? '0 : x_q + XW'(1);
               per_d = per_hit ? '0 : per_q + PW'(1);
               if (is_last) state_d = S_DONE;
               else decide = 1'b1;
            end
         end
         S_DONE: begin
            if (stop_in) begin
               state_d = S_IDLE;
               idx_d   = '0;
               x_d     = '0;
               per_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // a gap decision always advances the LFSR, whatever the mode
      if (decide) begin
         lfsr_d = lfsr_nxt;
         if (gap_g == '0) begin
            state_d = S_SEND;
         end else begin
            gap_d   = gap_g;
            state_d = S_STALL;
         end
      end
   end

   always_comb begin
      valid    = (state_q == S_SEND);
      busy     = (state_q == S_SEND) || (state_q == S_STALL);
      done     = (state_q == S_DONE);
      beat_cnt = idx_q;
      eol_out  = valid && is_eol;
      last_out = valid && is_last;
      data_out = '0;
      if (valid) begin
         for (int c = 0; c < NCH; c++) begin
            data_out[c*DW +: DW] = DW'(32'(idx_q) + 32'(c * CH_STEP));
         end
      end
   end

endmodule

// File: tb/tb_instream_gen.sv
// tb_instream_gen: scoreboard bench for instream_gen in gap modes 0, 1, 2.
// Three DUT instances share clk/reset; each has its own start/stop/ready.
module tb_instream_gen;

   typedef struct {
      logic [23:0] data;
      logic        eol;
      logic        last;
      int          idx;
   } beat_t;

   logic        clk;
   logic        rst;
   logic [2:0]  start_s;
   logic [2:0]  stop_s;
   logic [2:0]  ready_s;
   logic [2:0]  valid_w;
   logic [2:0]  eol_w;
   logic [2:0]  last_w;
   logic [2:0]  busy_w;
   logic [2:0]  done_w;
   logic [23:0] data_w [3];
   logic [3:0]  cnt0;
   logic [6:0]  cnt1;
   logic [3:0]  cnt2;

   logic [1:0]  sel;
   logic        mon_valid;
   logic        mon_eol;
   logic        mon_last;
   logic        mon_done;
   logic [23:0] mon_data;
   logic [31:0] mon_cnt;

   int    checks = 0;
   int    errors = 0;
   beat_t sb [$];
   bit    tl [$];

   instream_gen #(
      .NCH(3), .DW(8), .WIDTH(4), .HEIGHT(2), .STALL_MODE(0)
   ) u0 (
      .clk(clk), .reset(rst), .start_in(start_s[0]), .stop_in(stop_s[0]),
      .ready(ready_s[0]), .valid(valid_w[0]), .data_out(data_w[0]),
      .eol_out(eol_w[0]), .last_out(last_w[0]), .busy(busy_w[0]),
      .done(done_w[0]), .beat_cnt(cnt0)
   );

   instream_gen #(
      .NCH(3), .DW(8), .WIDTH(8), .HEIGHT(8), .STALL_MODE(1),
      .SEED(16'hACE1)
   ) u1 (
      .clk(clk), .reset(rst), .start_in(start_s[1]), .stop_in(stop_s[1]),
      .ready(ready_s[1]), .valid(valid_w[1]), .data_out(data_w[1]),
      .eol_out(eol_w[1]), .last_out(last_w[1]), .busy(busy_w[1]),
      .done(done_w[1]), .beat_cnt(cnt1)
   );

   instream_gen #(
      .NCH(3), .DW(8), .WIDTH(3), .HEIGHT(3), .STALL_MODE(2),
      .STALL_PERIOD(3), .STALL_LEN(2)
   ) u2 (
      .clk(clk), .reset(rst), .start_in(start_s[2]), .stop_in(stop_s[2]),
      .ready(ready_s[2]), .valid(valid_w[2]), .data_out(data_w[2]),
      .eol_out(eol_w[2]), .last_out(last_w[2]), .busy(busy_w[2]),
      .done(done_w[2]), .beat_cnt(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      mon_valid = valid_w[sel];
      mon_eol   = eol_w[sel];
      mon_last  = last_w[sel];
      mon_done  = done_w[sel];
      mon_data  = data_w[sel];
      case (sel)
         2'd1:    mon_cnt = 32'(cnt1);
         2'd2:    mon_cnt = 32'(cnt2);
         default: mon_cnt = 32'(cnt0);
      endcase
   end

   function automatic beat_t mk_beat(input int i, input int w, input int nb);
      beat_t b;
      for (int c = 0; c < 3; c++) b.data[c*8 +: 8] = 8'(i + c);
      b.eol  = ((i % w) == w - 1);
      b.last = (i == nb - 1);
      b.idx  = i;
      return b;
   endfunction

   task automatic apply_reset;
      rst     = 1'b1;
      start_s = '0;
      stop_s  = '0;
      ready_s = '1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Pulses start, then scores every offered beat against the queue.
   // Beat hold_idx is refused with ready low for hold_len cycles.
   task automatic run_frame(input logic [1:0] s, input int nb, input int w,
                            input int hold_idx, input int hold_len);
      int    hold;
      int    cyc;
      beat_t e;
      hold = 0;
      cyc  = 0;
      sel  = s;
      sb.delete();
      tl.delete();
      for (int i = 0; i < nb; i++) sb.push_back(mk_beat(i, w, nb));
      @(negedge clk);
      ready_s[s] = 1'b1;
      start_s[s] = 1'b1;
      @(negedge clk);
      start_s[s] = 1'b0;
      while (sb.size() > 0 && cyc < 4000) begin
         tl.push_back(mon_valid);
         if (mon_valid) begin
            e = sb[0];
            checks++;
            if (mon_data !== e.data || mon_eol !== e.eol ||
                mon_last !== e.last) begin
               errors++;
               $display("FAIL beat dut%0d idx %0d: got %h eol %b last %b, want %h eol %b last %b",
                        s, e.idx, mon_data, mon_eol, mon_last,
                        e.data, e.eol, e.last);
            end
            if (e.idx == hold_idx && hold < hold_len) begin
               ready_s[s] = 1'b0;
               hold++;
            end else begin
               ready_s[s] = 1'b1;
               void'(sb.pop_front());
            end
         end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL frame_timeout dut%0d: %0d beats missing, want 0",
                  s, sb.size());
      end
      checks++;
      if (mon_done !== 1'b1 || mon_valid !== 1'b0 || mon_cnt != 32'(nb)) begin
         errors++;
         $display("FAIL frame_end dut%0d: done %b valid %b cnt %0d, want 1 0 %0d",
                  s, mon_done, mon_valid, mon_cnt, nb);
      end
   endtask

   task automatic do_stop(input logic [1:0] s);
      stop_s[s] = 1'b1;
      @(negedge clk);
      stop_s[s] = 1'b0;
      checks++;
      if (done_w[s] !== 1'b0 || busy_w[s] !== 1'b0) begin
         errors++;
         $display("FAIL stop dut%0d: done %b busy %b, want 0 0",
                  s, done_w[s], busy_w[s]);
      end
   endtask

   task automatic test_reset;
      checks++;
      if (valid_w !== 3'b000 || busy_w !== 3'b000 || done_w !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: valid %b busy %b done %b, want 000",
                  valid_w, busy_w, done_w);
      end
      checks++;
      if (data_w[0] !== 24'h0 || eol_w[0] !== 1'b0 || last_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: data %h eol %b last %b, want 0",
                  data_w[0], eol_w[0], last_w[0]);
      end
      checks++;
      if (cnt0 !== 4'd0 || cnt1 !== 7'd0 || cnt2 !== 4'd0) begin
         errors++;
         $display("FAIL reset_cnt: %0d %0d %0d, want 0", cnt0, cnt1, cnt2);
      end
   endtask

   task automatic test_basic;
      int ones;
      run_frame(2'd0, 8, 4, -1, 0);
      ones = 0;
      foreach (tl[i]) if (tl[i]) ones++;
      checks++;
      if (tl.size() != 8 || ones != 8) begin
         errors++;
         $display("FAIL basic_timeline: %0d cycles %0d valid, want 8 8",
                  tl.size(), ones);
      end
      checks++;
      if (tl.size() == 0 || tl[0] !== 1'b1) begin
         errors++;
         $display("FAIL basic_latency: first cycle valid not seen, want valid at t+1");
      end
      do_stop(2'd0);
   endtask

   task automatic test_backpressure;
      run_frame(2'd0, 8, 4, 2, 5);
      checks++;
      if (tl.size() != 13) begin
         errors++;
         $display("FAIL bp_cycles: %0d, want 13", tl.size());
      end
      do_stop(2'd0);
   endtask

   task automatic test_fixed_gap;
      bit exp [$];
      int bad;
      for (int k = 0; k < 9; k++) begin
         exp.push_back(1'b1);
         if ((k + 1) % 3 == 0 && k != 8) begin
            exp.push_back(1'b0);
            exp.push_back(1'b0);
         end
      end
      run_frame(2'd2, 9, 3, -1, 0);
      bad = (tl.size() != exp.size()) ? 1 : 0;
      if (bad == 0) foreach (tl[i]) if (tl[i] != exp[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL fixed_gap_pattern: %0d cycles %0d diffs, want %0d cycles 0 diffs",
                  tl.size(), bad, exp.size());
      end
      do_stop(2'd2);
   endtask

   task automatic test_lfsr_gaps;
      bit          exp [$];
      bit          first [$];
      logic [15:0] l;
      int          g;
      int          run;
      int          bad;
      l = 16'hACE1;
      for (int k = 0; k < 64; k++) begin
         g = l[0] ? 1 + int'(l[5:1]) : 0;
         l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
         for (int j = 0; j < g; j++) exp.push_back(1'b0);
         exp.push_back(1'b1);
      end
      apply_reset;
      run_frame(2'd1, 64, 8, -1, 0);
      first = tl;
      bad = (tl.size() != exp.size()) ? 1 : 0;
      if (bad == 0) foreach (tl[i]) if (tl[i] != exp[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL lfsr_timeline: %0d cycles %0d diffs, want %0d cycles 0 diffs",
                  tl.size(), bad, exp.size());
      end
      run = 0;
      foreach (tl[i]) begin
         if (!tl[i]) begin
            run++;
         end else begin
            if (run > 0) begin
               checks++;
               if (run > 32) begin
                  errors++;
                  $display("FAIL lfsr_gap_len: %0d, want 1..32", run);
               end
            end
            run = 0;
         end
      end
      do_stop(2'd1);
      apply_reset;
      run_frame(2'd1, 64, 8, -1, 0);
      bad = (tl.size() != first.size()) ? 1 : 0;
      if (bad == 0) foreach (tl[i]) if (tl[i] != first[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL lfsr_repeat: %0d cycles %0d diffs, want %0d cycles 0 diffs",
                  tl.size(), bad, first.size());
      end
      do_stop(2'd1);
   endtask

   task automatic test_mid_reset;
      int cyc;
      bit hit;
      cyc = 0;
      hit = 0;
      sel = 2'd0;
      @(negedge clk);
      ready_s[0] = 1'b1;
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      while (!hit && cyc < 50) begin
         if (valid_w[0] && data_w[0][7:0] == 8'd5) begin
            hit = 1;
            rst = 1'b1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL mid_reset_wait: beat 5 not seen in %0d cycles", cyc);
      end
      @(negedge clk);
      checks++;
      if (valid_w[0] !== 1'b0 || cnt0 !== 4'd0 || busy_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: valid %b cnt %0d busy %b, want 0 0 0",
                  valid_w[0], cnt0, busy_w[0]);
      end
      rst = 1'b0;
      run_frame(2'd0, 8, 4, -1, 0);
      do_stop(2'd0);
   endtask

   task automatic test_done_hold;
      run_frame(2'd0, 8, 4, -1, 0);
      start_s[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (valid_w[0] !== 1'b0 || done_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL done_hold cyc %0d: valid %b done %b, want 0 1",
                     i, valid_w[0], done_w[0]);
         end
      end
      start_s[0] = 1'b0;
      stop_s[0]  = 1'b1;
      @(negedge clk);
      stop_s[0] = 1'b0;
      checks++;
      if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || cnt0 !== 4'd0) begin
         errors++;
         $display("FAIL done_stop: done %b busy %b cnt %0d, want 0 0 0",
                  done_w[0], busy_w[0], cnt0);
      end
      run_frame(2'd0, 8, 4, -1, 0);
      do_stop(2'd0);
   endtask

   initial begin
      sel = 2'd0;
      apply_reset;
      test_reset;
      test_basic;
      test_backpressure;
      test_fixed_gap;
      test_lfsr_gaps;
      test_mid_reset;
      test_done_hold;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
